game_state: RTL and testbench
=============================

// Module: game_state
// PURPOSE
//  Multi-mode up/down counter game. A COUNTER_SIZE-bit counter steps by +1/-1/+2/-2 per control.
//  Two score counters tally cycles where the counter is all-ones (win) or all-zeros (lose).
//  The game ends when either score reaches all-ones; the winner is then reported on 'who'.
//  Standalone block; outputs feed status display/logging logic.
// PARAMETERS
//  COUNTER_SIZE  4  width of game counter and i_value
//  SCORE_SIZE    4  width of win/lose score counters; game ends at score 2**SCORE_SIZE-1 (15)
// PORTS
//  clk       in   1             single clock, all state updates on rising edge
//  reset     in   1             synchronous, active-low reset (0 = reset on next rising clk edge)
//  control   in   2             00 up by 1, 01 down by 1, 10 up by 2, 11 down by 2
//  i_value   in   COUNTER_SIZE  counter load value, used when INIT=1
//  INIT      in   1             synchronous load of i_value into the counter
//  who       out  2             00 game running, 10 winner, 01 loser
//  los       out  1             counter is all zeros (lose event this cycle)
//  win       out  1             counter is all ones (win event this cycle)
//  gameover  out  1             a score reached all-ones; sticky until reset
// BEHAVIOUR
//  - Reset (reset=0 at clk edge): count=0, win_score=0, los_score=0, gameover=0, who=00.
//  - Counter update priority per edge: reset > gameover (freeze) > INIT (count<=i_value) > step.
//  - Step arithmetic modulo 2**COUNTER_SIZE, wraps silently (15+1=0, 0-1=15, 15+2=1, 1-2=15).
//  - win = (count==all-ones) & ~gameover & ~INIT; los = (count==0) & ~gameover & ~INIT.
//    Combinational decodes of the registered count; zero latency.
//  - Score: on each edge with win=1, win_score+=1; with los=1, los_score+=1 (never both).
//    INIT does not clear scores; only reset does.
//  - Game end: at the edge where win_score becomes all-ones, gameover<=1 and who<=10.
//    At the edge where los_score becomes all-ones, gameover<=1 and who<=01.
//    gameover/who visible the cycle after the 15th event.
//  - After gameover: count and scores hold, win=los=0, INIT ignored; only reset exits.
//  - Reset mid-game: all state cleared at that edge, regardless of INIT/control.
//  - Control may change any cycle; it takes effect on the next step.
// CONFIGURATION
//  GAME_SCORE_PORTS_EN defined:
//    adds outputs win_score[SCORE_SIZE-1:0] and los_score[SCORE_SIZE-1:0],
//    driven directly from the internal score registers.
//  GAME_SCORE_PORTS_EN undefined:
//    these ports do not exist; all other behaviour is identical.
// TESTING
//  - ctrl=00, i_value=0: INIT 1 cycle.
//    los on count=0 every 16 cycles; 15th los at cycle 224 after INIT; gameover=1, who=01 at cycle 225.
//  - ctrl=00, i_value=1 or 15 -> win first; who=10 (LOSER never reported).
//    ctrl=01, i_value=0/1 -> who=01; ctrl=01, i_value=15 -> who=10.
//  - ctrl=10/11, i_value=0 or 2 -> only even counts, win never fires; who=01 after 15 los, 8 cycles apart.
//    ctrl=10/11, i_value=1 or 15 -> only odd counts; who=10.
//  - Wrap: ctrl=00 from 15 -> next count 0; ctrl=11 from 1 -> 15. Both flag the proper win/los.
//  - After gameover: toggle INIT/control for 20 cycles -> count, scores, who unchanged, win=los=0.
//    reset=0 one edge -> all outputs back to reset values.
//  - reset=0 with INIT=1 in the same cycle -> count=0 (reset wins). Mid-game reset clears scores.

Source files
------------

// File: rtl/game_state.sv
// rtl/game_state.sv - up/down counter game with win/lose score tallies and sticky game-over
// Optional GAME_SCORE_PORTS_EN exposes the win_score/los_score registers as outputs.
module game_state #(
    parameter int COUNTER_SIZE = 4,
    parameter int SCORE_SIZE   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              control,
    input  logic [COUNTER_SIZE-1:0] i_value,
    input  logic                    INIT,
    output logic [1:0]              who,
    output logic                    los,
    output logic                    win,
    output logic                    gameover
`ifdef GAME_SCORE_PORTS_EN
    ,
    output logic [SCORE_SIZE-1:0]   win_score,
    output logic [SCORE_SIZE-1:0]   los_score
`endif
);

    localparam logic [COUNTER_SIZE-1:0] COUNT_FULL = {COUNTER_SIZE{1'b1}};
    localparam logic [SCORE_SIZE-1:0]   SCORE_FULL = {SCORE_SIZE{1'b1}};

    logic [COUNTER_SIZE-1:0] count;
`ifndef GAME_SCORE_PORTS_EN
    logic [SCORE_SIZE-1:0]   win_score;
    logic [SCORE_SIZE-1:0]   los_score;
`endif

    // Events are suppressed while loading or once the game has ended.
    assign win = (count == COUNT_FULL) & ~gameover & ~INIT;
    assign los = (count == '0) & ~gameover & ~INIT;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            win_score <= '0;
            los_score <= '0;
            gameover  <= 1'b0;
            who       <= 2'b00;
        end else if (!gameover) begin
            if (INIT) begin
                count <= i_value;
            end else begin
                case (control)
                    2'b00:   count <= count + COUNTER_SIZE'(1);
                    2'b01:   count <= count - COUNTER_SIZE'(1);
                    2'b10:   count <= count + COUNTER_SIZE'(2);
                    default: count <= count - COUNTER_SIZE'(2);
                endcase
            end
            if (win) begin
                win_score <= win_score + SCORE_SIZE'(1);
                if ((win_score + SCORE_SIZE'(1)) == SCORE_FULL) begin
                    gameover <= 1'b1;
                    who      <= 2'b10;
                end
            end
            if (los) begin
                los_score <= los_score + SCORE_SIZE'(1);
                if ((los_score + SCORE_SIZE'(1)) == SCORE_FULL) begin
                    gameover <= 1'b1;
                    who      <= 2'b01;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_state.sv
// tb/tb_game_state.sv - directed self-checking bench for game_state
module tb_game_state;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] control;
    logic [3:0] i_value;
    logic       INIT;
    logic [1:0] who;
    logic       los;
    logic       win;
    logic       gameover;
`ifdef GAME_SCORE_PORTS_EN
    logic [3:0] win_score;
    logic [3:0] los_score;
`endif

    int vectors = 0;
    int errors  = 0;

    game_state #(.COUNTER_SIZE(4), .SCORE_SIZE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .control  (control),
        .i_value  (i_value),
        .INIT     (INIT),
        .who      (who),
        .los      (los),
        .win      (win),
        .gameover (gameover)
`ifdef GAME_SCORE_PORTS_EN
        ,
        .win_score(win_score),
        .los_score(los_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ew, input logic el,
                           input logic eg, input logic [1:0] ewho);
        chk({tag, ".win"}, {1'b0, win}, {1'b0, ew});
        chk({tag, ".los"}, {1'b0, los}, {1'b0, el});
        chk({tag, ".gameover"}, {1'b0, gameover}, {1'b0, eg});
        chk({tag, ".who"}, who, ewho);
    endtask

    initial begin
        // Reset with INIT=1 in the same cycle: reset must win over the load.
        reset = 1'b0; INIT = 1'b1; i_value = 4'd5; control = 2'b00;
        step(); step();
        chk_all("rst_init", 1'b0, 1'b0, 1'b0, 2'b00);
        INIT = 1'b0;
        #1;
        chk_all("rst_cnt0", 1'b0, 1'b1, 1'b0, 2'b00);

        // ctrl=00 from 0: los every 16 cycles, 15th los at cycle 224.
        reset = 1'b1; INIT = 1'b1; i_value = 4'd0; control = 2'b00;
        step();
        INIT = 1'b0;
        #1;
        for (int k = 0; k <= 225; k++) begin
            chk_all($sformatf("up1_c%0d", k),
                    (k % 16 == 15) && (k < 225),
                    (k % 16 == 0) && (k <= 224),
                    k >= 225, (k >= 225) ? 2'b01 : 2'b00);
            if (k < 225) step();
        end

        // Frozen after game over: INIT and control toggling have no effect.
        for (int k = 0; k < 20; k++) begin
            INIT = k[0]; control = k[1:0]; i_value = 4'(k);
            step();
            chk_all($sformatf("frz_c%0d", k), 1'b0, 1'b0, 1'b1, 2'b01);
        end

        // Single reset edge returns everything to reset values.
        reset = 1'b0; INIT = 1'b0; control = 2'b00;
        step();
        chk_all("rst_after_go", 1'b0, 1'b1, 1'b0, 2'b00);

        // ctrl=10 from 2: even counts only, los every 8 cycles, 15th at cycle 119.
        reset = 1'b1; INIT = 1'b1; i_value = 4'd2; control = 2'b10;
        step();
        INIT = 1'b0;
        #1;
        for (int k = 0; k <= 120; k++) begin
            chk_all($sformatf("up2_c%0d", k), 1'b0,
                    (k % 8 == 7) && (k <= 119),
                    k >= 120, (k >= 120) ? 2'b01 : 2'b00);
            if (k < 120) step();
        end

        // ctrl=00 from 15: wrap 15->0 flags win then los; accumulate a few scores.
        reset = 1'b0;
        step();
        reset = 1'b1; INIT = 1'b1; i_value = 4'd15; control = 2'b00;
        step();
        INIT = 1'b0;
        #1;
        for (int k = 0; k <= 40; k++) begin
            chk_all($sformatf("wrap_c%0d", k),
                    k % 16 == 0, k % 16 == 1, 1'b0, 2'b00);
            if (k < 40) step();
        end

        // Mid-game reset with INIT=1 clears scores; full win timing below proves it.
        reset = 1'b0; INIT = 1'b1; i_value = 4'd9;
        step();
        chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 2'b00);

        // ctrl=11 from 1: 1-2 wraps to 15, odd counts only, 15th win at cycle 113.
        reset = 1'b1; INIT = 1'b1; i_value = 4'd1; control = 2'b11;
        step();
        INIT = 1'b0;
        #1;
        for (int k = 0; k <= 114; k++) begin
            chk_all($sformatf("dn2_c%0d", k),
                    (k % 8 == 1) && (k <= 113), 1'b0,
                    k >= 114, (k >= 114) ? 2'b10 : 2'b00);
            if (k < 114) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
